// File: rtl/user_uart_rx.sv
// user_uart_rx: oversampling 8N1 UART receiver with a 255-entry FIFO and DATA/STATUS bus words.
// Define USER_UART_RX_PARITY_EN for 8E1 frames with a functional parity_err flag.
module user_uart_rx #(
    parameter int UART_RX_CLK_DIV = 434
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_uart_rx,
    output logic        o_rx_valid,
    input  logic        rd_req_i,
    output logic        rd_gnt_o,
    input  logic [31:0] rd_addr_i,
    output logic [31:0] rd_data_o,
    input  logic        wr_req_i,
    output logic        wr_gnt_o,
    input  logic [31:0] wr_addr_i,
    input  logic [31:0] wr_data_i,
    input  logic [3:0]  wr_be_i
);
    localparam int CW = $clog2(UART_RX_CLK_DIV);
    localparam logic [CW-1:0] HALF = CW'(UART_RX_CLK_DIV / 2 - 1);
    localparam logic [CW-1:0] FULL = CW'(UART_RX_CLK_DIV - 1);

`ifdef USER_UART_RX_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

    state_t      state_q, state_d;
    logic [1:0]  sync_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  shreg_q, shreg_d;
    logic [7:0]  wr_ptr_q, rd_ptr_q, fifo_len;
    logic [7:0]  mem [256];
    logic [2:0]  flags_q, flags_d, clr;
    logic [31:0] rd_data_q, rd_data_d;
    logic        rxs, perr, stop_hit, full, empty, push, pop;
    logic        set_ferr, set_perr, set_ovr, rd_word, wr_word;
    logic        unused_bits;

    assign rxs = sync_q[1];

`ifdef USER_UART_RX_PARITY_EN
    logic perr_q, perr_d;
    assign perr = perr_q;
    always_ff @(posedge clk) begin
        if (rst) perr_q <= 1'b0;
        else     perr_q <= perr_d;
    end
`else
    assign perr = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q + 1'b1;
        bit_d    = bit_q;
        shreg_d  = shreg_q;
        stop_hit = 1'b0;
`ifdef USER_UART_RX_PARITY_EN
        perr_d   = perr_q;
`endif
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (!rxs) state_d = S_START;
            end
            S_START: if (cnt_q == HALF) begin
                cnt_d   = '0;
                bit_d   = '0;
                state_d = rxs ? S_IDLE : S_DATA;
            end
            S_DATA: if (cnt_q == FULL) begin
                cnt_d   = '0;
                shreg_d = {rxs, shreg_q[7:1]};
                bit_d   = bit_q + 3'd1;
`ifdef USER_UART_RX_PARITY_EN
                if (bit_q == 3'd7) state_d = S_PARITY;
`else
                if (bit_q == 3'd7) state_d = S_STOP;
`endif
            end
`ifdef USER_UART_RX_PARITY_EN
            S_PARITY: if (cnt_q == FULL) begin
                cnt_d   = '0;
                perr_d  = rxs ^ (^shreg_q);
                state_d = S_STOP;
            end
`endif
            // Leave at mid stop bit so a back-to-back start edge is not missed.
            S_STOP: if (cnt_q == FULL) begin
                cnt_d    = '0;
                stop_hit = 1'b1;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign fifo_len = wr_ptr_q - rd_ptr_q;
    assign empty    = fifo_len == 8'd0;
    assign full     = fifo_len == 8'hFF;
    assign set_ferr = stop_hit & ~rxs;
    assign set_perr = stop_hit & rxs & perr;
    assign set_ovr  = stop_hit & rxs & ~perr & full;
    assign push     = stop_hit & rxs & ~perr & ~full;

    assign rd_gnt_o   = rd_req_i;
    assign wr_gnt_o   = wr_req_i;
    assign rd_word    = rd_addr_i[31:3] == 29'd0;
    assign wr_word    = wr_addr_i[31:3] == 29'd0;
    assign pop        = rd_req_i & rd_word & ~rd_addr_i[2] & ~empty;
    assign clr        = (wr_req_i & wr_word & wr_addr_i[2] & wr_be_i[1]) ? wr_data_i[10:8] : 3'b000;
    assign flags_d    = (flags_q & ~clr) | {set_perr, set_ferr, set_ovr};
    assign rd_data_d  = !(rd_req_i && rd_word) ? 32'd0 :
                        rd_addr_i[2] ? {21'd0, flags_q, fifo_len} :
                        {23'd0, ~empty, empty ? 8'd0 : mem[rd_ptr_q]};
    assign rd_data_o  = rd_data_q;
    assign o_rx_valid = ~empty;
    assign unused_bits = ^{rd_addr_i[1:0], wr_addr_i[1:0], wr_data_i[31:11], wr_data_i[7:0],
                           wr_be_i[3:2], wr_be_i[0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q    <= 2'b11;
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            bit_q     <= '0;
            shreg_q   <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            flags_q   <= '0;
            rd_data_q <= '0;
        end else begin
            sync_q    <= {sync_q[0], i_uart_rx};
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            shreg_q   <= shreg_d;
            wr_ptr_q  <= wr_ptr_q + {7'd0, push};
            rd_ptr_q  <= rd_ptr_q + {7'd0, pop};
            flags_q   <= flags_d;
            rd_data_q <= rd_data_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= shreg_q;
    end
endmodule
